// File: rtl/frank_cu_pkg.sv
// frank_cu_pkg: shared definitions for the microcoded control unit.
//   - sequencer state encoding
//   - datapath control-bus field positions and the microcode LAST flag position
//   - default execute-cycle budget per instruction
package frank_cu_pkg;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_t;

    localparam int CB_W_DEF    = 17;
    localparam int MAX_CYC_DEF = 4;

    // Control-bus field indices
    localparam int JUMP       = 16;
    localparam int J_MODE_HI  = 15;
    localparam int J_MODE_LO  = 14;
    localparam int CALL       = 13;
    localparam int RETURN     = 12;
    localparam int ADDRIN     = 11;
    localparam int FRIN       = 10;
    localparam int WREGIN_HI  = 9;
    localparam int WREGIN_LO  = 8;
    localparam int ALUIN1     = 7;
    localparam int ALUIN2     = 6;
    localparam int FRR        = 5;
    localparam int PCW        = 4;
    localparam int ADDRW      = 3;
    localparam int FRW        = 2;
    localparam int WREGW      = 1;
    localparam int STATUSW    = 0;

    // Microcode word is {last, ctrl[CB_W-1:0]}; last sits at bit CB_W
    localparam int LAST_BIT   = CB_W_DEF;

endpackage

// File: rtl/cu_microseq_if.sv
// cu_microseq_if: decode-side / datapath-side signal bundle of the sequencer.
//   i_en            sequencer enable (0 = stall)
//   i_control_input opcode, sampled in FETCH
//   i_flush         abort current instruction
//   i_uc_we/addr/data microcode write port, data = {last, ctrl}
//   o_control_bus   datapath control strobes
//   o_step          current execute step
//   o_busy          1 while executing
//   o_done          1 in the final execute cycle
// Modports: master drives the inputs (decoder/loader), slave is the sequencer.
interface cu_microseq_if #(
    parameter int OPC_W  = 4,
    parameter int CB_W   = 17,
    parameter int STEP_W = 2
);
    logic                    i_en;
    logic [OPC_W-1:0]        i_control_input;
    logic                    i_flush;
    logic                    i_uc_we;
    logic [OPC_W+STEP_W-1:0] i_uc_addr;
    logic [CB_W:0]           i_uc_data;
    logic [CB_W-1:0]         o_control_bus;
    logic [STEP_W-1:0]       o_step;
    logic                    o_busy;
    logic                    o_done;

    modport master (
        output i_en, i_control_input, i_flush, i_uc_we, i_uc_addr, i_uc_data,
        input  o_control_bus, o_step, o_busy, o_done
    );

    modport slave (
        input  i_en, i_control_input, i_flush, i_uc_we, i_uc_addr, i_uc_data,
        output o_control_bus, o_step, o_busy, o_done
    );
endinterface

// File: rtl/cu_ucode_ram.sv
// cu_ucode_ram: microcode store, synchronous write / asynchronous read.
//   clk      write clock
//   we       write strobe
//   wr_addr  {opcode, step} write address; step >= MAX_CYC is dropped
//   wr_data  {last, ctrl}
//   rd_addr  {opcode, step} read address
//   rd_data  combinational read data (old data during a same-cycle write)
module cu_ucode_ram #(
    parameter int OPC_W   = 4,
    parameter int STEP_W  = 2,
    parameter int MAX_CYC = 4,
    parameter int DATA_W  = 18
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [OPC_W+STEP_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [OPC_W+STEP_W-1:0] rd_addr,
    output logic [DATA_W-1:0]       rd_data
);
    localparam int ADDR_W = OPC_W + STEP_W;
    localparam int DEPTH  = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              step_ok;

    assign step_ok = int'(wr_addr[STEP_W-1:0]) < MAX_CYC;

    always_ff @(posedge clk) begin
        if (we && step_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/cu_microseq.sv
// cu_microseq: microcoded control-unit sequencer.
//   i_clk    clock, all state updates on rising edge
//   i_rst_n  synchronous active-low reset (priority over everything)
//   bus      cu_microseq_if.slave: enable, opcode, flush, microcode write port,
//            control bus / step / busy / done outputs
// FETCH latches the opcode when enabled; EXEC steps through ucode[{opc, step}]
// until an entry with LAST set or step MAX_CYC-1, then returns to FETCH.
module cu_microseq
    import frank_cu_pkg::*;
#(
    parameter int OPC_W   = 4,
    parameter int CB_W    = CB_W_DEF,
    parameter int MAX_CYC = MAX_CYC_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    cu_microseq_if.slave bus
);
    localparam int STEP_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_t            state, state_n;
    logic [STEP_W-1:0] step, step_n;
    logic [OPC_W-1:0]  opc, opc_n;

    logic [CB_W:0]     uc_word;
    logic              uc_last;
    logic              term;

    logic [CB_W-1:0]   ctrl_out;
    logic              busy_out;
    logic              done_out;

    // Writes during a reset cycle are discarded
    cu_ucode_ram #(
        .OPC_W   (OPC_W),
        .STEP_W  (STEP_W),
        .MAX_CYC (MAX_CYC),
        .DATA_W  (CB_W + 1)
    ) u_ram (
        .clk     (i_clk),
        .we      (bus.i_uc_we & i_rst_n),
        .wr_addr (bus.i_uc_addr),
        .wr_data (bus.i_uc_data),
        .rd_addr ({opc, step}),
        .rd_data (uc_word)
    );

    assign uc_last = uc_word[CB_W];
    assign term    = uc_last | (step == STEP_W'(MAX_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_FETCH;
            step  <= '0;
            opc   <= '0;
        end else begin
            state <= state_n;
            step  <= step_n;
            opc   <= opc_n;
        end
    end

    always_comb begin
        state_n  = state;
        step_n   = step;
        opc_n    = opc;
        ctrl_out = '0;
        busy_out = 1'b0;
        done_out = 1'b0;

        unique case (state)
            ST_FETCH: begin
                step_n = '0;
                if (!bus.i_flush && bus.i_en) begin
                    state_n = ST_EXEC;
                    opc_n   = bus.i_control_input;
                end
            end
            ST_EXEC: begin
                busy_out = 1'b1;
                // Stall suppresses both strobes and completion; flush only the strobes
                done_out = bus.i_en & term;
                if (bus.i_en && !bus.i_flush) begin
                    ctrl_out = uc_word[CB_W-1:0];
                end
                if (bus.i_flush) begin
                    state_n = ST_FETCH;
                    step_n  = '0;
                end else if (bus.i_en) begin
                    if (term) begin
                        state_n = ST_FETCH;
                        step_n  = '0;
                    end else begin
                        step_n = step + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_FETCH;
                step_n  = '0;
            end
        endcase
    end

    assign bus.o_control_bus = ctrl_out;
    assign bus.o_step        = step;
    assign bus.o_busy        = busy_out;
    assign bus.o_done        = done_out;
endmodule

// File: doc/cu_microseq.md
Name: cu_microseq

Overview:
Parametrised microcoded successor to the FRANK6000 hardwired control unit. The fixed per-opcode case tables become a writable microcode store, indexed by {opcode, step}. Each instruction runs up to MAX_CYC execute cycles, with a per-entry "last" flag, plus flush and stall. The block sits between instruction decode and the datapath write/select strobes.

Parameters:
OPC_W, 4, opcode width (i_control_input)
CB_W, 17, control bus width (datapath strobe vector)
MAX_CYC, 4, max execute cycles per instruction (>=1); STEP_W = max(1, clog2(MAX_CYC)) is a localparam

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst_n  in  1  synchronous reset, active-low
i_en  in  1  sequencer enable; 0 = stall
i_control_input  in  OPC_W  opcode, sampled only in FETCH
i_flush  in  1  abort current instruction
i_uc_we  in  1  microcode write strobe
i_uc_addr  in  OPC_W+STEP_W  write address {opcode, step}
i_uc_data  in  CB_W+1  {last, ctrl[CB_W-1:0]}
o_control_bus  out  CB_W  datapath control strobes
o_step  out  STEP_W  current execute step
o_busy  out  1  1 while in EXEC
o_done  out  1  1 in the final execute cycle of an instruction

Behaviour:
- Reset: on rising edge with i_rst_n=0: state=FETCH, step=0, opcode latch=0. Outputs are then all 0. A write asserted in a reset cycle is ignored. Reset has priority over all other inputs. Microcode contents are not reset.
- States:
  - FETCH: outputs 0, except o_step=0. On an edge with i_en=1, latch i_control_input and go to EXEC with step=0.
  - EXEC: entry E = ucode[{opc, step}].
    - o_control_bus = E.ctrl (combinational read). o_busy=1, o_step=step.
    - o_done = E.last | (step==MAX_CYC-1).
    - On an edge with i_en=1: if o_done, go to FETCH and set step=0; else step+1.
- Stall (i_en=0): state, step and opcode hold. o_control_bus=0 and o_done=0. o_busy and o_step still reflect the held state.
- Flush: i_flush=1 on an edge → FETCH, step=0, whatever the value of i_en. o_control_bus is forced to 0 in any cycle where i_flush=1.
- Latency:
  - Single-cycle instruction: 2 clocks (FETCH + 1 EXEC).
  - N-step instruction: N+1 clocks.
  - Forced end at MAX_CYC steps even if no entry has last set.
- Microcode store: 2^OPC_W × MAX_CYC words of CB_W+1 bits.
  - Synchronous write, asynchronous read.
  - A write to the entry currently being read takes effect from the next cycle. The current-cycle output shows the old data.
  - Writes are accepted in any state and regardless of i_en.
  - Addresses with step ≥ MAX_CYC (when MAX_CYC is not a power of 2) are ignored.
- Opcode latch changes only on the FETCH→EXEC transition. Changes on i_control_input during EXEC have no effect.

Decomposition:
- Package frank_cu_pkg holds:
  - state encodings ST_FETCH and ST_EXEC;
  - control-bus field indices (JUMP=16, J_MODE=15:14, CALL=13, RETURN=12, ADDRin=11, FRin=10, WREGin=9:8, ALUin1=7, ALUin2=6, FRr=5, PCw=4, ADDRw=3, FRw=2, WREGw=1, STATUSw=0);
  - the LAST flag position (CB_W);
  - default MAX_CYC.
- Sub-module cu_ucode_ram: parametrised write-sync/read-async store. The sequencer FSM and step counter stay in cu_microseq.

Test Plan:
- 1-step: write addr {1,0} = {1,17'h00018}; reset; i_en=1, input=1 → cycle 1 FETCH with bus 0; cycle 2 bus=17'h00018, o_done=1, o_busy=1; cycle 3 FETCH with bus 0.
- 2-step: write {2,0}={0,17'h00420} and {2,1}={1,17'h00212}; input=2 → bus 17'h00420 (step 0, done 0), then 17'h00212 (step 1, done 1), then FETCH. Changing input to 5 mid-instruction has no effect.
- Stall: during step 0 of opcode 2, drive i_en=0 for 3 cycles → bus 0, o_step=0, o_busy=1 held. On release, bus=17'h00420, then 17'h00212 completes.
- Forced end: opcode 3 with all 4 entries last=0 and ctrl=17'h10000+step → bus 17'h10000..17'h10003 over 4 EXEC cycles, o_done=1 on step 3, then FETCH.
- Flush: i_flush=1 during step 0 of opcode 2 → bus 0 that cycle, FETCH the next cycle, step 1 never issued. Flush with i_en=0 also aborts.
- Reset mid-op: i_rst_n=0 during step 1 → after the edge: FETCH, step 0, all outputs 0. A simultaneous i_uc_we write is not stored (a readback via an opcode executes the old value).
